sb_tx_transaction_fsm: RTL and testbench
========================================

Name: sb_tx_transaction_fsm

Overview:
Sideband transmit transaction framer. It is the transmit-side counterpart of the sideband receive transaction FSM.
- Accepts one transaction request (AT command, AT response, or LT lane-state) from the logical-layer control.
- Emits the framed byte stream DLE, STX/LSE, payload, CRC, DLE, ETX, with DLE byte-stuffing, to the sideband serializer over a valid/ready byte interface.
- Sits between the register/LT control logic and the SBTX serializer.

Parameters:
DLE_SYMBOL, 8'hFE, data-link escape byte
STX_CMD_SYMBOL, 8'h05, STX for AT command
STX_RSP_SYMBOL, 8'h04, STX for AT response
ETX_SYMBOL, 8'h40, end-of-transaction byte
CRC_INIT, 16'hFFFF, CRC-16 seed
CRC_POLY, 16'h8005, CRC-16 polynomial (x^16+x^15+x^2+1)

Ports:
sb_clk  in  1  sideband clock; single clock domain
rst  in  1  asynchronous, active-low reset
tconnect  in  1  link connected; leave DISCONNECT
tdisconnect  in  1  abort and go to DISCONNECT
tx_start  in  1  request pulse; sampled only when tx_busy=0
tx_type  in  2  0=AT command, 1=AT response, 2=LT, 3=reserved (ignored)
tx_address  in  8  register address byte
tx_write  in  1  1=write, 0=read; goes to len byte bit7
tx_len  in  2  data byte count, 0..3
tx_payload  in  24  data; byte0=[7:0] sent first
tx_lse  in  8  lane-state byte for LT; CLSE is ~tx_lse
sbtx_data  out  8  byte to serializer
sbtx_valid  out  1  sbtx_data valid
sbtx_ready  in  1  serializer accepts byte when valid&ready
tx_busy  out  1  transaction in progress
tx_done  out  1  one-cycle pulse after final ETX accepted
disconnect  out  1  1 while in DISCONNECT

Behaviour:
- Reset values: all outputs 0 except disconnect=1. State is DISCONNECT.
- Request capture:
  - tx_start is accepted in IDLE only. All tx_* inputs are latched on that edge and later input changes are ignored.
  - tx_type=3 is dropped.
  - tx_start in any other state is ignored.
- Latency: sbtx_valid=1 with DLE on the cycle after acceptance. tx_busy=1 from that same cycle until tx_done.
- Byte handshake: a byte advances only when sbtx_valid&sbtx_ready. While valid&!ready, sbtx_data and state must hold. Valid stays 1 between consecutive bytes when ready=1, giving one byte per cycle.
- States: DISCONNECT, IDLE, DLE1, STX, HDR_ADDR, HDR_LEN, DATA, CRC_LO, CRC_HI, STUFF, DLE2, ETX, LSE, CLSE.
- DISCONNECT->IDLE on tconnect.
- AT sequence: DLE1 (FE) -> STX (05 or 04) -> HDR_ADDR (tx_address) -> HDR_LEN ({tx_write,5'b0,tx_len}) -> DATA x N -> CRC_LO (crc[7:0]) -> CRC_HI (crc[15:8]) -> DLE2 (FE) -> ETX (40) -> IDLE.
- N (data bytes in DATA):
  - command: N = tx_write ? tx_len : 0
  - response: N = tx_write ? 0 : tx_len
  - N=0 skips DATA.
- LT sequence: DLE1 -> LSE (tx_lse) -> CLSE (~tx_lse) -> DLE2 -> ETX -> IDLE. No CRC, no stuffing.
- Stuffing: in HDR_ADDR, HDR_LEN, DATA, CRC_LO, CRC_HI, a byte equal to FE is followed by STUFF, which re-sends FE, before the sequence advances. STX, DLE1, DLE2 and ETX are never stuffed.
- CRC:
  - Reset to CRC_INIT on acceptance.
  - Updated MSB-first, one byte per accepted byte, over STX, HDR_ADDR, HDR_LEN and DATA (unstuffed values only).
  - CRC bytes and STUFF bytes are excluded.
- Data byte counter is 2 bits and indexes tx_payload byte k = [8k+7:8k].
- tx_done: pulses for one cycle on the edge after ETX is accepted, coincident with the return to IDLE. A new tx_start is legal on the cycle tx_done is high.
- Simultaneous events and aborts:
  - tdisconnect has priority over tconnect and tx_start.
  - tdisconnect in any state: next state DISCONNECT, sbtx_valid=0, tx_busy=0, no tx_done. A partial frame is dropped.
  - Async reset mid-frame: same effect, immediately.
  - tconnect in IDLE is a no-op.

Decomposition:
- Package sb_pkg holds:
  - DLE/STX/ETX constants
  - tx_type encodings
  - the state enum
  - CRC_INIT and CRC_POLY
- Constants are shared with the receive FSM.
- Sub-module sb_crc16: byte-serial CRC-16 with ports sb_clk, rst, init, en, din[7:0], crc[15:0]. It is reused by the receiver CRC check.

Test Plan:
- Write command, address 0x08, len 3, payload 0x123456, ready=1 -> FE 05 08 83 56 34 12 cL cH FE 40 on consecutive cycles; the two CRC bytes match the golden CRC-16 over 05 08 83 56 34 12; tx_done pulses one cycle after 40.
- Read command, address 0xFE, len 2 -> FE 05 FE FE 02 cL cH FE 40 (address stuffed, no data); CRC excludes the stuff byte.
- LT, tx_lse=0x80 -> FE 80 7F FE 40, no CRC; response with len 1, payload 0xFE -> data byte sent as FE FE.
- Backpressure: drop sbtx_ready for 3 cycles mid-DATA -> sbtx_data and valid held stable; no byte lost or duplicated; a tx_start pulsed while busy is ignored.
- tdisconnect asserted during CRC_LO -> next cycle sbtx_valid=0, disconnect=1, no tx_done. tconnect then tx_start -> clean full frame.
- rst low mid-frame -> outputs return to reset values asynchronously; the first frame after release has correct CRC from CRC_INIT.

Source files
------------

// File: rtl/sb_pkg.sv
// Sideband link constants, transaction encodings and shared helpers.
// Shared by the transmit framer and the receive transaction FSM.
package sb_pkg;

   localparam logic [7:0]  DLE_SYMBOL     = 8'hFE;
   localparam logic [7:0]  STX_CMD_SYMBOL = 8'h05;
   localparam logic [7:0]  STX_RSP_SYMBOL = 8'h04;
   localparam logic [7:0]  ETX_SYMBOL     = 8'h40;
   localparam logic [15:0] CRC_INIT       = 16'hFFFF;
   localparam logic [15:0] CRC_POLY       = 16'h8005;

   typedef enum logic [1:0] {
      TX_TYPE_CMD  = 2'd0,
      TX_TYPE_RSP  = 2'd1,
      TX_TYPE_LT   = 2'd2,
      TX_TYPE_RSVD = 2'd3
   } tx_type_e;

   typedef enum logic [3:0] {
      ST_DISCONNECT = 4'd0,
      ST_IDLE       = 4'd1,
      ST_DLE1       = 4'd2,
      ST_STX        = 4'd3,
      ST_HDR_ADDR   = 4'd4,
      ST_HDR_LEN    = 4'd5,
      ST_DATA       = 4'd6,
      ST_CRC_LO     = 4'd7,
      ST_CRC_HI     = 4'd8,
      ST_STUFF      = 4'd9,
      ST_DLE2       = 4'd10,
      ST_ETX        = 4'd11,
      ST_LSE        = 4'd12,
      ST_CLSE       = 4'd13
   } sb_state_e;

   // One byte of CRC-16, non-reflected, MSB of the byte first, no final xor.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  din);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ din[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      return c;
   endfunction

endpackage

// File: rtl/sb_crc16.sv
// Byte-serial CRC-16 accumulator; init reseeds, en folds in one byte.
module sb_crc16
   import sb_pkg::*;
(
   input  logic        sb_clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   // Seed takes priority over an update so a new frame always starts clean.
   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc16_byte(crc_q, din);
      end
   end

   // Accumulator register.
   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sb_tx_transaction_fsm.sv
// Sideband transmit framer: turns one latched request into the byte stream
// DLE, STX/LSE, header, data, CRC, DLE, ETX with DLE stuffing.
module sb_tx_transaction_fsm
   import sb_pkg::*;
(
   input  logic        sb_clk,
   input  logic        rst,
   input  logic        tconnect,
   input  logic        tdisconnect,
   input  logic        tx_start,
   input  logic [1:0]  tx_type,
   input  logic [7:0]  tx_address,
   input  logic        tx_write,
   input  logic [1:0]  tx_len,
   input  logic [23:0] tx_payload,
   input  logic [7:0]  tx_lse,
   output logic [7:0]  sbtx_data,
   output logic        sbtx_valid,
   input  logic        sbtx_ready,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        disconnect
);

   sb_state_e   state_q, state_d;
   sb_state_e   ret_q, ret_d;
   sb_state_e   follow;
   logic [1:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   tx_type_e    type_q;
   logic [7:0]  addr_q;
   logic        write_q;
   logic [1:0]  len_q;
   logic [23:0] payload_q;
   logic [7:0]  lse_q;
   logic [1:0]  n_q;
   logic [1:0]  n_in;
   logic        accept;
   logic        fire;
   logic        stuffable;
   logic        crc_en;
   logic [15:0] crc;

   assign accept     = (state_q == ST_IDLE) && tx_start && !tdisconnect &&
                       (tx_type != TX_TYPE_RSVD);
   assign fire       = sbtx_valid && sbtx_ready;
   assign sbtx_valid = (state_q != ST_DISCONNECT) && (state_q != ST_IDLE);
   assign tx_busy    = sbtx_valid;
   assign tx_done    = done_q;
   assign disconnect = (state_q == ST_DISCONNECT);
   assign stuffable  = (state_q == ST_HDR_ADDR) || (state_q == ST_HDR_LEN) ||
                       (state_q == ST_DATA) || (state_q == ST_CRC_LO) ||
                       (state_q == ST_CRC_HI);
   assign crc_en     = fire && ((state_q == ST_STX) || (state_q == ST_HDR_ADDR) ||
                                (state_q == ST_HDR_LEN) || (state_q == ST_DATA));

   // Data bytes carried: writes carry data in commands, reads carry it in responses.
   always_comb begin
      n_in = 2'd0;
      if (tx_type == TX_TYPE_CMD) begin
         n_in = tx_write ? tx_len : 2'd0;
      end else if (tx_type == TX_TYPE_RSP) begin
         n_in = tx_write ? 2'd0 : tx_len;
      end
   end

   // Byte presented for the current state; held stable while stalled.
   always_comb begin
      sbtx_data = 8'h00;
      case (state_q)
         ST_DLE1, ST_DLE2, ST_STUFF: sbtx_data = DLE_SYMBOL;
         ST_STX:      sbtx_data = (type_q == TX_TYPE_CMD) ? STX_CMD_SYMBOL : STX_RSP_SYMBOL;
         ST_HDR_ADDR: sbtx_data = addr_q;
         ST_HDR_LEN:  sbtx_data = {write_q, 5'b00000, len_q};
         ST_DATA:     sbtx_data = payload_q[{cnt_q, 3'b000} +: 8];
         ST_CRC_LO:   sbtx_data = crc[7:0];
         ST_CRC_HI:   sbtx_data = crc[15:8];
         ST_ETX:      sbtx_data = ETX_SYMBOL;
         ST_LSE:      sbtx_data = lse_q;
         ST_CLSE:     sbtx_data = ~lse_q;
         default:     sbtx_data = 8'h00;
      endcase
   end

   // State that follows the current byte once it is accepted (ignoring stuffing).
   always_comb begin
      follow = state_q;
      case (state_q)
         ST_DLE1:     follow = (type_q == TX_TYPE_LT) ? ST_LSE : ST_STX;
         ST_STX:      follow = ST_HDR_ADDR;
         ST_HDR_ADDR: follow = ST_HDR_LEN;
         ST_HDR_LEN:  follow = (n_q == 2'd0) ? ST_CRC_LO : ST_DATA;
         ST_DATA:     follow = (cnt_q == n_q - 2'd1) ? ST_CRC_LO : ST_DATA;
         ST_CRC_LO:   follow = ST_CRC_HI;
         ST_CRC_HI:   follow = ST_DLE2;
         ST_STUFF:    follow = ret_q;
         ST_LSE:      follow = ST_CLSE;
         ST_CLSE:     follow = ST_DLE2;
         ST_DLE2:     follow = ST_ETX;
         ST_ETX:      follow = ST_IDLE;
         default:     follow = state_q;
      endcase
   end

   // Next-state logic; tdisconnect overrides everything else.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_DISCONNECT: begin
            if (tconnect) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_DLE1;
               cnt_d   = 2'd0;
            end
         end
         default: begin
            if (fire) begin
               if (stuffable && (sbtx_data == DLE_SYMBOL)) begin
                  state_d = ST_STUFF;
                  ret_d   = follow;
               end else begin
                  state_d = follow;
               end
               if (state_q == ST_DATA) cnt_d = cnt_q + 2'd1;
               if (state_q == ST_ETX)  done_d = 1'b1;
            end
         end
      endcase
      if (tdisconnect) begin
         state_d = ST_DISCONNECT;
         done_d  = 1'b0;
      end
   end

   // State, counters and the request latch.
   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_DISCONNECT;
         ret_q     <= ST_IDLE;
         cnt_q     <= 2'd0;
         done_q    <= 1'b0;
         type_q    <= TX_TYPE_CMD;
         addr_q    <= 8'h00;
         write_q   <= 1'b0;
         len_q     <= 2'd0;
         payload_q <= 24'h000000;
         lse_q     <= 8'h00;
         n_q       <= 2'd0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (accept) begin
            type_q    <= tx_type_e'(tx_type);
            addr_q    <= tx_address;
            write_q   <= tx_write;
            len_q     <= tx_len;
            payload_q <= tx_payload;
            lse_q     <= tx_lse;
            n_q       <= n_in;
         end
      end
   end

   sb_crc16 u_crc (
      .sb_clk (sb_clk),
      .rst    (rst),
      .init   (accept),
      .en     (crc_en),
      .din    (sbtx_data),
      .crc    (crc)
   );

endmodule

// File: tb/tb_sb_tx_transaction_fsm.sv
// Directed bench for the sideband transmit framer.
module tb_sb_tx_transaction_fsm;

   logic        sb_clk = 1'b0;
   logic        rst = 1'b0;
   logic        tconnect = 1'b0;
   logic        tdisconnect = 1'b0;
   logic        tx_start = 1'b0;
   logic [1:0]  tx_type = 2'd0;
   logic [7:0]  tx_address = 8'h00;
   logic        tx_write = 1'b0;
   logic [1:0]  tx_len = 2'd0;
   logic [23:0] tx_payload = 24'h0;
   logic [7:0]  tx_lse = 8'h00;
   logic [7:0]  sbtx_data;
   logic        sbtx_valid;
   logic        sbtx_ready = 1'b1;
   logic        tx_busy;
   logic        tx_done;
   logic        disconnect;

   int          n_cmp = 0;
   int          n_err = 0;
   int          negcnt = 0;
   int          done_cnt = 0;
   int          done_t = 0;
   logic [7:0]  got_q[$];
   int          got_t[$];
   logic [7:0]  exp_q[$];
   logic [15:0] c;
   int          d0;
   bit          ok;

   sb_tx_transaction_fsm dut (
      .sb_clk(sb_clk), .rst(rst), .tconnect(tconnect), .tdisconnect(tdisconnect),
      .tx_start(tx_start), .tx_type(tx_type), .tx_address(tx_address),
      .tx_write(tx_write), .tx_len(tx_len), .tx_payload(tx_payload), .tx_lse(tx_lse),
      .sbtx_data(sbtx_data), .sbtx_valid(sbtx_valid), .sbtx_ready(sbtx_ready),
      .tx_busy(tx_busy), .tx_done(tx_done), .disconnect(disconnect)
   );

   always #5 sb_clk = ~sb_clk;

   // Record every byte handed over, and tx_done pulses, away from the active edge.
   always @(negedge sb_clk) begin
      negcnt++;
      if (sbtx_valid && sbtx_ready) begin
         got_q.push_back(sbtx_data);
         got_t.push_back(negcnt);
      end
      if (tx_done) begin
         done_cnt++;
         done_t = negcnt;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference CRC-16: byte xored into the top, then eight shifts.
   function automatic logic [15:0] gold_crc(input logic [7:0] b[$]);
      logic [15:0] r;
      r = 16'hFFFF;
      foreach (b[i]) begin
         r = r ^ {b[i], 8'h00};
         for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
      end
      return r;
   endfunction

   task automatic push_stuffed(input logic [7:0] b);
      exp_q.push_back(b);
      if (b == 8'hFE) exp_q.push_back(8'hFE);
   endtask

   // Append CRC bytes (stuffed when needed) and the DLE ETX trailer.
   task automatic add_crc_tail(input logic [7:0] body[$]);
      logic [15:0] r;
      r = gold_crc(body);
      push_stuffed(r[7:0]);
      push_stuffed(r[15:8]);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'h40);
   endtask

   task automatic start_req(input logic [1:0] ty, input logic [7:0] ad, input logic wr,
                            input logic [1:0] ln, input logic [23:0] pl, input logic [7:0] ls);
      @(posedge sb_clk); #1;
      tx_start = 1'b1; tx_type = ty; tx_address = ad; tx_write = wr;
      tx_len = ln; tx_payload = pl; tx_lse = ls;
      @(posedge sb_clk); #1;
      tx_start = 1'b0;
      // Scramble the request inputs so only latched values can be framed.
      tx_address = 8'hA5; tx_write = ~wr; tx_len = ~ln; tx_payload = 24'hC3C3C3;
      tx_lse = 8'h5A; tx_type = 2'd1;
   endtask

   task automatic wait_done(input int bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge sb_clk);
         if (tx_done) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bytes(input string tag, input int nb);
      for (int i = 0; i < 60 && got_q.size() < nb; i++) @(posedge sb_clk);
      #1;
      check(tag, got_q.size(), nb);
   endtask

   task automatic check_frame(input string tag, input bit contig);
      int n;
      check({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
      if (contig && n > 0) begin
         check({tag, "_contig"}, got_t[got_q.size()-1] - got_t[0], got_q.size() - 1);
         check({tag, "_donelat"}, done_t - got_t[got_q.size()-1], 1);
      end
      $display("frame %s: %0d bytes observed", tag, got_q.size());
      got_q.delete();
      got_t.delete();
   endtask

   task automatic run_frame(input string tag, input logic [1:0] ty, input logic [7:0] ad,
                            input logic wr, input logic [1:0] ln, input logic [23:0] pl,
                            input logic [7:0] ls);
      int  base;
      bit  f;
      base = done_cnt;
      start_req(ty, ad, wr, ln, pl, ls);
      check({tag, "_valid1"}, sbtx_valid, 1'b1);
      check({tag, "_dle1"}, sbtx_data, 8'hFE);
      check({tag, "_busy"}, tx_busy, 1'b1);
      wait_done(80, f);
      check({tag, "_done_seen"}, f, 1'b1);
      @(posedge sb_clk); #1;
      check({tag, "_done_once"}, done_cnt - base, 1);
      check({tag, "_idle_busy"}, tx_busy, 1'b0);
      check_frame(tag, 1'b1);
   endtask

   task automatic connect();
      @(posedge sb_clk); #1 tconnect = 1'b1;
      @(posedge sb_clk); #1 tconnect = 1'b0;
      check("connect_disc", disconnect, 1'b0);
      check("connect_valid", sbtx_valid, 1'b0);
   endtask

   task automatic exp_write_cmd();
      logic [7:0] body[$];
      body = '{8'h05, 8'h08, 8'h83, 8'h56, 8'h34, 8'h12};
      exp_q = '{8'hFE, 8'h05, 8'h08, 8'h83, 8'h56, 8'h34, 8'h12};
      add_crc_tail(body);
   endtask

   task automatic exp_read_cmd();
      logic [7:0] body[$];
      body = '{8'h05, 8'hFE, 8'h02};
      exp_q = '{8'hFE, 8'h05, 8'hFE, 8'hFE, 8'h02};
      add_crc_tail(body);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge sb_clk);
      #1;
      check("rst_disc", disconnect, 1'b1);
      check("rst_valid", sbtx_valid, 1'b0);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_data", sbtx_data, 8'h00);
      rst = 1'b1;
      // tx_start in DISCONNECT is ignored
      start_req(2'd0, 8'h08, 1'b1, 2'd3, 24'h123456, 8'h00);
      check("disc_start_valid", sbtx_valid, 1'b0);
      check("disc_start_disc", disconnect, 1'b1);
      connect();

      // Write command, 3 data bytes
      exp_write_cmd();
      run_frame("wr_cmd", 2'd0, 8'h08, 1'b1, 2'd3, 24'h123456, 8'h00);

      // Read command to address FE: address stuffed, no data
      exp_read_cmd();
      run_frame("rd_cmd", 2'd0, 8'hFE, 1'b0, 2'd2, 24'h998877, 8'h00);

      // Lane-state transaction
      exp_q = '{8'hFE, 8'h80, 8'h7F, 8'hFE, 8'h40};
      run_frame("lt", 2'd2, 8'h33, 1'b1, 2'd3, 24'h111111, 8'h80);

      // Read response with one data byte equal to FE
      begin
         logic [7:0] body[$];
         body = '{8'h04, 8'h10, 8'h01, 8'hFE};
         exp_q = '{8'hFE, 8'h04, 8'h10, 8'h01, 8'hFE, 8'hFE};
         add_crc_tail(body);
      end
      run_frame("rsp_fe", 2'd1, 8'h10, 1'b0, 2'd1, 24'h0000FE, 8'h00);

      // Reserved type is dropped
      start_req(2'd3, 8'h01, 1'b1, 2'd1, 24'h000001, 8'h00);
      check("rsvd_valid", sbtx_valid, 1'b0);
      check("rsvd_busy", tx_busy, 1'b0);
      repeat (3) @(posedge sb_clk);
      #1;
      check("rsvd_bytes", got_q.size(), 0);

      // Backpressure mid-DATA, with a tx_start while busy
      exp_write_cmd();
      d0 = done_cnt;
      start_req(2'd0, 8'h08, 1'b1, 2'd3, 24'h123456, 8'h00);
      wait_bytes("bp_wait", 5);
      sbtx_ready = 1'b0;
      tx_start = 1'b1; tx_type = 2'd2; tx_lse = 8'h11;
      @(negedge sb_clk);
      check("bp_hold_v0", sbtx_valid, 1'b1);
      check("bp_hold_d0", sbtx_data, 8'h34);
      @(posedge sb_clk); #1 tx_start = 1'b0;
      @(negedge sb_clk);
      check("bp_hold_v1", sbtx_valid, 1'b1);
      check("bp_hold_d1", sbtx_data, 8'h34);
      @(negedge sb_clk);
      check("bp_hold_d2", sbtx_data, 8'h34);
      @(posedge sb_clk); #1 sbtx_ready = 1'b1;
      wait_done(80, ok);
      check("bp_done_seen", ok, 1'b1);
      @(posedge sb_clk); #1;
      check("bp_done_once", done_cnt - d0, 1);
      check_frame("bp", 1'b0);
      repeat (4) @(posedge sb_clk);
      #1;
      check("bp_no_extra_valid", sbtx_valid, 1'b0);
      check("bp_no_extra_bytes", got_q.size(), 0);

      // tdisconnect during CRC_LO
      exp_write_cmd();
      d0 = done_cnt;
      start_req(2'd0, 8'h08, 1'b1, 2'd3, 24'h123456, 8'h00);
      wait_bytes("dc_wait", 7);
      check("dc_crc_lo", sbtx_data, exp_q[7]);
      tdisconnect = 1'b1;
      @(posedge sb_clk); #1 tdisconnect = 1'b0;
      check("dc_valid", sbtx_valid, 1'b0);
      check("dc_disc", disconnect, 1'b1);
      check("dc_busy", tx_busy, 1'b0);
      repeat (4) @(posedge sb_clk);
      #1;
      check("dc_no_done", done_cnt - d0, 0);
      got_q.delete(); got_t.delete();
      connect();
      exp_read_cmd();
      run_frame("after_dc", 2'd0, 8'hFE, 1'b0, 2'd2, 24'h0, 8'h00);

      // Asynchronous reset mid-frame
      start_req(2'd1, 8'h10, 1'b0, 2'd1, 24'h0000FE, 8'h00);
      wait_bytes("rst_wait", 3);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", sbtx_valid, 1'b0);
      check("arst_disc", disconnect, 1'b1);
      check("arst_busy", tx_busy, 1'b0);
      check("arst_data", sbtx_data, 8'h00);
      @(posedge sb_clk); #1 rst = 1'b1;
      got_q.delete(); got_t.delete();
      connect();
      exp_write_cmd();
      run_frame("after_rst", 2'd0, 8'h08, 1'b1, 2'd3, 24'h123456, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
